// File: rtl/serial_mag_comp_ctrl_if.sv
// rtl/serial_mag_comp_ctrl_if.sv - request and 1-bit comparator signals of serial_mag_comp_ctrl
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             err;
  logic             cmp_a;
  logic             cmp_b;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;

  modport slave (
    input  start, a, b, cmp_gt, cmp_eq, cmp_lt,
    output busy, done, gt, eq, lt, err, cmp_a, cmp_b
  );

  modport master (
    output start, a, b, cmp_gt, cmp_eq, cmp_lt,
    input  busy, done, gt, eq, lt, err, cmp_a, cmp_b
  );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// rtl/serial_mag_comp_ctrl.sv - MSB-first serial magnitude compare over one shared 1-bit comparator
// Optional comparator response checking: define SERIAL_CMP_CHECK_EN.
module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_mag_comp_ctrl_if.slave io
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             gt_q, gt_n;
  logic             eq_q, eq_n;
  logic             lt_q, lt_n;
  logic             done_q, done_n;
  logic             bit_a, bit_b;

`ifdef SERIAL_CMP_CHECK_EN
  logic err_q, err_n;
  logic proto_ok;

  // The expected response is itself one-hot, so this also covers the one-hot rule.
  assign proto_ok = ({io.cmp_gt, io.cmp_eq, io.cmp_lt} ==
                     {bit_a & ~bit_b, ~(bit_a ^ bit_b), ~bit_a & bit_b});
  assign io.err   = err_q;
`else
  assign io.err   = 1'b0;
`endif

  assign bit_a    = (state == RUN) ? a_q[idx] : 1'b0;
  assign bit_b    = (state == RUN) ? b_q[idx] : 1'b0;
  assign io.cmp_a = bit_a;
  assign io.cmp_b = bit_b;
  assign io.busy  = (state == RUN);
  assign io.done  = done_q;
  assign io.gt    = gt_q;
  assign io.eq    = eq_q;
  assign io.lt    = lt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_CMP_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      idx    <= idx_n;
      gt_q   <= gt_n;
      eq_q   <= eq_n;
      lt_q   <= lt_n;
      done_q <= done_n;
`ifdef SERIAL_CMP_CHECK_EN
      err_q  <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    idx_n   = idx;
    gt_n    = gt_q;
    eq_n    = eq_q;
    lt_n    = lt_q;
    done_n  = 1'b0;
`ifdef SERIAL_CMP_CHECK_EN
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (io.start) begin
          a_n     = io.a;
          b_n     = io.b;
          idx_n   = IDX_W'(WIDTH - 1);
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
`ifdef SERIAL_CMP_CHECK_EN
        if (!proto_ok) begin
          err_n   = 1'b1;
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
          state_n = IDLE;
        end else
`endif
        // An all-zero response falls through to the equal path.
        if (io.cmp_gt) begin
          gt_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (io.cmp_lt) begin
          lt_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          idx_n   = idx - IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb/tb_serial_mag_comp_ctrl.sv - randomized self-checking bench for serial_mag_comp_ctrl
module tb_serial_mag_comp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject = 1'b0;
  int   total = 0;
  int   bad = 0;

  serial_mag_comp_ctrl_if #(.WIDTH(8)) io8 ();
  serial_mag_comp_ctrl_if #(.WIDTH(1)) io1 ();

  serial_mag_comp_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .io(io8.slave));
  serial_mag_comp_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .io(io1.slave));

  always #5 clk = ~clk;

  // External 1-bit comparators; inject forces gt and lt together on io8.
  always_comb begin
    io8.cmp_gt = inject | (io8.cmp_a & ~io8.cmp_b);
    io8.cmp_lt = inject | (~io8.cmp_a & io8.cmp_b);
    io8.cmp_eq = ~inject & ~(io8.cmp_a ^ io8.cmp_b);
    io1.cmp_gt = io1.cmp_a & ~io1.cmp_b;
    io1.cmp_lt = ~io1.cmp_a & io1.cmp_b;
    io1.cmp_eq = ~(io1.cmp_a ^ io1.cmp_b);
  end

  function automatic int model_k(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = a ^ b;
    for (int i = 7; i >= 0; i--) if (diff[i]) return 8 - i;
    return 8;
  endfunction

  function automatic logic [2:0] model_flags(input logic [7:0] a, input logic [7:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // Called at a negedge; returns at the negedge where done or err is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit hold, input bit scramble,
                      input int inject_at, output int cycles, output logic [7:0] sa,
                      output logic [7:0] sb, output bit busy_ok, output bit clr_ok,
                      output logic [2:0] flags, output logic errv);
    int n;
    n = 0;
    io8.start = 1'b1; io8.a = a; io8.b = b;
    sa = '0; sb = '0; busy_ok = 1'b1; clr_ok = 1'b1; cycles = -1; flags = 3'b111; errv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!hold) io8.start = 1'b0;
      if (scramble) begin io8.a = 8'($urandom); io8.b = 8'($urandom); end
      if (io8.done || io8.err) begin
        cycles = c + 1;
        flags = {io8.gt, io8.eq, io8.lt};
        errv = io8.err;
        break;
      end
      n++;
      if (!io8.busy) busy_ok = 1'b0;
      if ({io8.gt, io8.eq, io8.lt} != 3'b000) clr_ok = 1'b0;
      sa = {sa[6:0], io8.cmp_a};
      sb = {sb[6:0], io8.cmp_b};
      inject = (n == inject_at);
    end
    inject = 1'b0;
    io8.start = 1'b0;
  endtask

  task automatic test_reset();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev; int dones;
    @(negedge clk);
    total++;
    if ({io8.busy, io8.done, io8.gt, io8.eq, io8.lt, io8.err, io8.cmp_a, io8.cmp_b} !== 8'h00) begin
      bad++; $display("FAIL reset_state got=%b exp=00000000",
        {io8.busy, io8.done, io8.gt, io8.eq, io8.lt, io8.err, io8.cmp_a, io8.cmp_b});
    end
    rst = 1'b0;
    @(negedge clk);
    io8.start = 1'b1; io8.a = 8'hAA; io8.b = 8'hAA;
    @(negedge clk);
    io8.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({io8.busy, io8.done, io8.gt, io8.eq, io8.lt, io8.cmp_a, io8.cmp_b} !== 7'h00) begin
      bad++; $display("FAIL reset_mid_run got=%b exp=0000000",
        {io8.busy, io8.done, io8.gt, io8.eq, io8.lt, io8.cmp_a, io8.cmp_b});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin @(negedge clk); if (io8.done || io8.busy) dones++; end
    total++;
    if (dones != 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", dones); end
    run8(8'h3C, 8'h3D, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl} !== {32'd9, 3'b001}) begin
      bad++; $display("FAIL reset_recover got=%0d/%b exp=9/001", cyc, fl);
    end
  endtask

  task automatic test_msb();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev;
    @(negedge clk);
    run8(8'h80, 8'h7F, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl, sa, sb, bok} !== {32'd2, 3'b100, 8'h01, 8'h00, 1'b1}) begin
      bad++; $display("FAIL msb_diff got=%0d/%b/%h/%h/%b exp=2/100/01/00/1", cyc, fl, sa, sb, bok);
    end
    @(negedge clk);
    total++;
    if ({io8.done, io8.gt} !== 2'b01) begin
      bad++; $display("FAIL done_one_cycle got=%b exp=01", {io8.done, io8.gt});
    end
  endtask

  task automatic test_lsb();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev;
    @(negedge clk);
    run8(8'h12, 8'h13, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl, sa, sb} !== {32'd9, 3'b001, 8'h12, 8'h13}) begin
      bad++; $display("FAIL lsb_diff got=%0d/%b/%h/%h exp=9/001/12/13", cyc, fl, sa, sb);
    end
  endtask

  task automatic test_hold();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev; int lost;
    @(negedge clk);
    run8(8'h5C, 8'h5C, 1, 1, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl, sa, sb, bok} !== {32'd9, 3'b010, 8'h5C, 8'h5C, 1'b1}) begin
      bad++; $display("FAIL equal_hold got=%0d/%b/%h/%h/%b exp=9/010/5c/5c/1", cyc, fl, sa, sb, bok);
    end
    lost = 0;
    repeat (6) begin
      io8.a = 8'($urandom); io8.b = 8'($urandom);
      @(negedge clk);
      if ({io8.gt, io8.eq, io8.lt, io8.busy} != 4'b0100) lost++;
    end
    total++;
    if (lost != 0) begin bad++; $display("FAIL eq_held got=%0d exp=0", lost); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev;
    @(negedge clk);
    run8(8'h00, 8'h40, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl} !== {32'd3, 3'b001}) begin
      bad++; $display("FAIL b2b_first got=%0d/%b exp=3/001", cyc, fl);
    end
    run8(8'h01, 8'h00, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
    total++;
    if ({cyc, fl, cok, bok} !== {32'd9, 3'b100, 1'b1, 1'b1}) begin
      bad++; $display("FAIL b2b_second got=%0d/%b/%b/%b exp=9/100/1/1", cyc, fl, cok, bok);
    end
  endtask

  task automatic test_random();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev;
    logic [7:0] a, b, ea, eb; int k;
    for (int it = 0; it < 40; it++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      k = model_k(a, b);
      ea = a >> (8 - k);
      eb = b >> (8 - k);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run8(a, b, 0, 0, 0, cyc, sa, sb, bok, cok, fl, ev);
      total++;
      if ({cyc, fl, sa, sb, bok, cok, ev} !== {k + 1, model_flags(a, b), ea, eb, 1'b1, 1'b1, 1'b0}) begin
        bad++; $display("FAIL random a=%h b=%h got=%0d/%b/%h/%h/%b%b%b exp=%0d/%b/%h/%h/110",
          a, b, cyc, fl, sa, sb, bok, cok, ev, k + 1, model_flags(a, b), ea, eb);
      end
    end
  endtask

  task automatic test_width1();
    logic av, bv;
    logic [1:0] tbl [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) {av, bv} = tbl[i];
      else {av, bv} = 2'($urandom);
      @(negedge clk);
      io1.start = 1'b1; io1.a = av; io1.b = bv;
      @(negedge clk);
      io1.start = 1'b0;
      total++;
      if ({io1.busy, io1.cmp_a, io1.cmp_b} !== {1'b1, av, bv}) begin
        bad++; $display("FAIL w1_run got=%b exp=%b", {io1.busy, io1.cmp_a, io1.cmp_b}, {1'b1, av, bv});
      end
      @(negedge clk);
      total++;
      if ({io1.done, io1.gt, io1.eq, io1.lt} !== {1'b1, av > bv, av == bv, av < bv}) begin
        bad++; $display("FAIL w1_result got=%b exp=%b", {io1.done, io1.gt, io1.eq, io1.lt},
          {1'b1, av > bv, av == bv, av < bv});
      end
    end
  endtask

  task automatic test_check();
    int cyc; logic [7:0] sa, sb; bit bok, cok; logic [2:0] fl; logic ev;
    @(negedge clk);
    run8(8'hFF, 8'hFF, 0, 0, 3, cyc, sa, sb, bok, cok, fl, ev);
`ifdef SERIAL_CMP_CHECK_EN
    total++;
    if ({cyc, io8.done, ev, fl} !== {32'd4, 1'b0, 1'b1, 3'b000}) begin
      bad++; $display("FAIL check_abort got=%0d/%b/%b/%b exp=4/0/1/000", cyc, io8.done, ev, fl);
    end
`else
    total++;
    if ({cyc, ev, fl} !== {32'd4, 1'b0, 3'b100}) begin
      bad++; $display("FAIL check_priority got=%0d/%b/%b exp=4/0/100", cyc, ev, fl);
    end
`endif
    @(negedge clk);
    total++;
    if ({io8.err, io8.done, io8.busy} !== 3'b000) begin
      bad++; $display("FAIL check_after got=%b exp=000", {io8.err, io8.done, io8.busy});
    end
  endtask

  initial begin
    io8.start = 1'b0; io8.a = '0; io8.b = '0;
    io1.start = 1'b0; io1.a = '0; io1.b = '0;
    test_reset();
    test_msb();
    test_lsb();
    test_hold();
    test_back_to_back();
    test_random();
    test_width1();
    test_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_mag_comp_ctrl.md
Name: serial_mag_comp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands by time-multiplexing one external 1-bit magnitude comparator.
- Bits are presented MSB first. The comparison stops at the first unequal bit.
- Sits between a requesting datapath (start/done handshake) and a shared 1-bit comparator: drives its A/B inputs and samples its GT/EQ/LT outputs.

Parameters:
WIDTH, 8, operand width in bits; legal range 1 to 64; index counter is max(1, $clog2(WIDTH)) bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle completion pulse
gt  output  1  result A > B; held until next accepted start
eq  output  1  result A == B; held
lt  output  1  result A < B; held
err  output  1  comparator protocol error pulse (see Optional Feature)
cmp_a  output  1  bit of A presented to the 1-bit comparator
cmp_b  output  1  bit of B presented to the 1-bit comparator
cmp_gt  input  1  comparator GT, combinational response to cmp_a/cmp_b
cmp_eq  input  1  comparator EQ
cmp_lt  input  1  comparator LT

Behaviour:
- Single clock domain, clk. rst is asynchronous and active-high: assertion forces IDLE immediately, including mid-comparison.
- Reset values:
  - busy, done, gt, eq, lt, err, cmp_a, cmp_b = 0
  - Operand registers and idx = 0
- States: IDLE, RUN.
- IDLE:
  - On start=1, latch a→a_q, b→b_q and set idx=WIDTH-1.
  - Clear gt/eq/lt to 0 and go to RUN.
  - start=0 leaves state unchanged.
- RUN:
  - cmp_a=a_q[idx] and cmp_b=b_q[idx], driven combinationally from registers.
  - cmp_a and cmp_b are 0 in IDLE.
  - busy=1 for every RUN cycle.
  - Each RUN clock edge samples the comparator:
    - cmp_gt=1: gt←1, done←1, go to IDLE.
    - cmp_lt=1: lt←1, done←1, go to IDLE.
    - cmp_eq=1 and idx==0: eq←1, done←1, go to IDLE.
    - cmp_eq=1 and idx>0: idx←idx-1, stay in RUN.
- Latency:
  - Start accepted at edge E0. k = bits examined, 1 ≤ k ≤ WIDTH; k = index distance from MSB to first differing bit, plus 1.
  - Decision at edge E0+k.
  - done=1 for exactly the cycle after E0+k; result valid from that cycle.
  - Worst case, equal operands: done in cycle WIDTH+1 after start.
- done is a registered one-cycle pulse. It is cleared at the next edge unless a new decision occurs there, which is impossible: a minimum of 1 RUN cycle separates starts.
- start asserted during the done cycle is accepted (state is IDLE). Back-to-back throughput is therefore one comparison per k+1 cycles.
- start while busy is ignored. Operands are not re-sampled; a/b may change freely after acceptance.
- gt/eq/lt are mutually exclusive. They hold their last result until the next accepted start, or reset.
- WIDTH=1: single RUN cycle, idx stays 0.
- Comparator response with none of gt/lt/eq set, and macro absent: treated as eq (continue or finish as eq). Priority order is gt > lt > eq.

Optional Feature:
- Macro: SERIAL_CMP_CHECK_EN.
- Defined:
  - Each RUN cycle checks that {cmp_gt,cmp_eq,cmp_lt} is one-hot. It also checks consistency with cmp_a/cmp_b: gt = a&~b, lt = ~a&b, eq = ~(a^b).
  - On violation, abort: go to IDLE, err=1 for one cycle (same timing as done), done=0, gt/eq/lt all 0.
- Undefined: no checking; err tied to 0; priority rule above applies.

Test Plan:
- Reset mid-RUN: WIDTH=8, start a=8'hAA b=8'hAA, assert rst after 3 cycles → busy/done/gt/eq/lt/cmp_a/cmp_b = 0 immediately; no done pulse follows. After release, a new start completes normally.
- MSB difference: a=8'h80 b=8'h7F → exactly 1 RUN cycle; done in cycle 2 after start; gt=1, eq=0, lt=0.
- LSB difference: a=8'h12 b=8'h13 → 8 RUN cycles; cmp_a/cmp_b walk bits 7..0; lt=1; done cycle 9.
- Equal operands and hold: a=b=8'h5C → eq=1 after 8 RUN cycles. start is held high while busy and a/b are changed mid-run → ignored; eq stays 1 until the next accepted start.
- Back-to-back: start high in the done cycle with a=8'h01 b=8'h00 → accepted at once; previous result cleared; gt=1 after 8 RUN cycles. Also WIDTH=1: a=1 b=0 → gt in 1 RUN cycle.
- With SERIAL_CMP_CHECK_EN: force cmp_gt=cmp_lt=1 on bit 5 → err pulse for 1 cycle, done=0, flags 0, state IDLE. Without the macro, the same stimulus yields gt=1.
